sram_rd_arb: RTL and testbench

SRAM_RD_ARB -- requirements
Module: sram_rd_arb

---
 rtl/sram_rd_arb.sv | 111 +++++++++++
 tb/tb_sram_rd_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rd_arb.sv
// sram_rd_arb
//   Two-requester read arbiter in front of a single-cycle-latency SRAM, with
//   a pass-through write port and same-cycle read-after-write bypass.
//
//   Ports
//     clk, rst                 single clock, asynchronous active-high reset
//     req0_i/addr0_i           requester 0 level request and read address
//     gnt0_o/vld0_o            requester 0 grant (request cycle) / return valid
//     req1_i/addr1_i           requester 1, same meaning
//     gnt1_o/vld1_o            requester 1, same meaning
//     rddata_o                 shared read-return data, 0 when nothing returns
//     wren_i/wraddr_i/wrdata_i single writer, never stalled
//     sram_wren_o/sram_wraddr_o/sram_wrdata_o  SRAM write port drive
//     sram_rden_o/sram_rdaddr_o                SRAM read port drive
//     sram_rddata_i            registered SRAM read data, valid 1 cycle after rden
module sram_rd_arb #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    output logic                  gnt0_o,
    output logic                  vld0_o,
    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    output logic                  gnt1_o,
    output logic                  vld1_o,
    output logic [DATA_WIDTH-1:0] rddata_o,
    input  logic                  wren_i,
    input  logic [ADDR_WIDTH-1:0] wraddr_i,
    input  logic [DATA_WIDTH-1:0] wrdata_i,
    output logic                  sram_wren_o,
    output logic [ADDR_WIDTH-1:0] sram_wraddr_o,
    output logic [DATA_WIDTH-1:0] sram_wrdata_o,
    output logic                  sram_rden_o,
    output logic [ADDR_WIDTH-1:0] sram_rdaddr_o,
    input  logic [DATA_WIDTH-1:0] sram_rddata_i
);

    logic                  prio_q;      // requester that wins the next tie
    logic                  vld0_q;
    logic                  vld1_q;
    logic                  byp_q;       // return must come from byp_data_q
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic                  byp_hit;

    // Write path is a straight wire; reset does not touch it.
    assign sram_wren_o   = wren_i;
    assign sram_wraddr_o = wraddr_i;
    assign sram_wrdata_o = wrdata_i;

    // Grants are held low during reset so no read is launched while the
    // return pipeline is being cleared.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise a latch is inferred.
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (!rst) begin
            if (req0_i && (!req1_i || !prio_q)) begin
                gnt0_o = 1'b1;
            end else if (req1_i) begin
                gnt1_o = 1'b1;
            end
        end
    end

    assign sram_rden_o   = gnt0_o | gnt1_o;
    assign sram_rdaddr_o = gnt1_o ? addr1_i : addr0_i;

    // The SRAM returns the pre-write contents when a read and a write hit
    // the same address in one cycle, so capture the new data instead. A
    // write in any later cycle is deliberately not looked at.
    assign byp_hit = sram_rden_o && wren_i && (wraddr_i == sram_rdaddr_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q     <= 1'b0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            vld0_q <= gnt0_o;
            vld1_q <= gnt1_o;
            if (sram_rden_o) begin
                // Winner hands priority to the other requester.
                prio_q <= gnt0_o;
            end
            byp_q <= byp_hit;
            if (byp_hit) begin
                byp_data_q <= wrdata_i;
            end
        end
    end

    assign vld0_o = vld0_q;
    assign vld1_o = vld1_q;

    always_comb begin
        rddata_o = '0;
        if (vld0_q || vld1_q) begin
            rddata_o = byp_q ? byp_data_q : sram_rddata_i;
        end
    end

endmodule

// File: tb/tb_sram_rd_arb.sv
// tb_sram_rd_arb
//   Directed bench for sram_rd_arb with a behavioural 1-cycle-latency SRAM
//   (read returns the pre-write contents on a same-cycle collision).
module tb_sram_rd_arb;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_i, req1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic          gnt0_o, gnt1_o, vld0_o, vld1_o;
    logic [DW-1:0] rddata_o;
    logic          wren_i;
    logic [AW-1:0] wraddr_i;
    logic [DW-1:0] wrdata_i;
    logic          sram_wren_o, sram_rden_o;
    logic [AW-1:0] sram_wraddr_o, sram_rdaddr_o;
    logic [DW-1:0] sram_wrdata_o;
    logic [DW-1:0] sram_rddata_i;

    int checks = 0;
    int errors = 0;

    sram_rd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_i        (req0_i),
        .addr0_i       (addr0_i),
        .gnt0_o        (gnt0_o),
        .vld0_o        (vld0_o),
        .req1_i        (req1_i),
        .addr1_i       (addr1_i),
        .gnt1_o        (gnt1_o),
        .vld1_o        (vld1_o),
        .rddata_o      (rddata_o),
        .wren_i        (wren_i),
        .wraddr_i      (wraddr_i),
        .wrdata_i      (wrdata_i),
        .sram_wren_o   (sram_wren_o),
        .sram_wraddr_o (sram_wraddr_o),
        .sram_wrdata_o (sram_wrdata_o),
        .sram_rden_o   (sram_rden_o),
        .sram_rdaddr_o (sram_rdaddr_o),
        .sram_rddata_i (sram_rddata_i)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read, read sees the old word on a collision.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_rden_o) sram_rddata_i <= mem[sram_rdaddr_o];
        if (sram_wren_o) mem[sram_wraddr_o] <= sram_wrdata_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wren_i   = 1'b1;
        wraddr_i = a;
        wrdata_i = d;
        cyc();
        wren_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_i = 1'b1; req1_i = 1'b1;
        addr0_i = 12'h010; addr1_i = 12'h020;
        wren_i = 1'b1; wraddr_i = 12'h005; wrdata_i = 16'h1234;
        #2;
        checks++; if (gnt0_o !== 1'b0 || gnt1_o !== 1'b0) begin errors++;
            $display("FAIL reset_gnt got %0b%0b exp 00", gnt0_o, gnt1_o); end
        checks++; if (sram_rden_o !== 1'b0) begin errors++;
            $display("FAIL reset_rden got %0b exp 0", sram_rden_o); end
        checks++; if (vld0_o !== 1'b0 || vld1_o !== 1'b0) begin errors++;
            $display("FAIL reset_vld got %0b%0b exp 00", vld0_o, vld1_o); end
        checks++; if (rddata_o !== 16'h0000) begin errors++;
            $display("FAIL reset_rddata got %h exp 0000", rddata_o); end
        checks++; if (sram_wren_o !== 1'b1 || sram_wraddr_o !== 12'h005 || sram_wrdata_o !== 16'h1234) begin errors++;
            $display("FAIL reset_wr_pass got %0b %h %h exp 1 005 1234", sram_wren_o, sram_wraddr_o, sram_wrdata_o); end
        cyc();
        req0_i = 1'b0; req1_i = 1'b0; wren_i = 1'b0;
        // Preload the SRAM through the write pass-through while in reset.
        wr(12'h010, 16'h1111);
        wr(12'h020, 16'h2222);
        wr(12'h3A5, 16'h0001);
        wr(12'h100, 16'h5555);
        for (int i = 0; i < 16; i++) wr(AW'(i), 16'hA000 + DW'(i));
        checks++; if (vld0_o !== 1'b0 || vld1_o !== 1'b0 || rddata_o !== 16'h0000) begin errors++;
            $display("FAIL reset_hold got vld %0b%0b data %h exp 00 0000", vld0_o, vld1_o, rddata_o); end
        rst = 1'b0;
    endtask

    task automatic test_tie_after_reset();
        req0_i = 1'b1; req1_i = 1'b1; addr0_i = 12'h010; addr1_i = 12'h020;
        #1;
        checks++; if (gnt0_o !== 1'b1 || gnt1_o !== 1'b0) begin errors++;
            $display("FAIL tie_c1_gnt got %0b%0b exp 10", gnt0_o, gnt1_o); end
        checks++; if (sram_rden_o !== 1'b1 || sram_rdaddr_o !== 12'h010) begin errors++;
            $display("FAIL tie_c1_rd got %0b %h exp 1 010", sram_rden_o, sram_rdaddr_o); end
        cyc();
        req0_i = 1'b0;
        #1;
        checks++; if (vld0_o !== 1'b1 || vld1_o !== 1'b0 || rddata_o !== 16'h1111) begin errors++;
            $display("FAIL tie_c2_ret got vld %0b%0b data %h exp 10 1111", vld0_o, vld1_o, rddata_o); end
        checks++; if (gnt1_o !== 1'b1 || gnt0_o !== 1'b0 || sram_rdaddr_o !== 12'h020) begin errors++;
            $display("FAIL tie_c2_gnt got %0b%0b %h exp 01 020", gnt0_o, gnt1_o, sram_rdaddr_o); end
        cyc();
        req1_i = 1'b0; addr0_i = 12'h007; addr1_i = 12'h009;
        #1;
        checks++; if (vld1_o !== 1'b1 || vld0_o !== 1'b0 || rddata_o !== 16'h2222) begin errors++;
            $display("FAIL tie_c3_ret got vld %0b%0b data %h exp 01 2222", vld0_o, vld1_o, rddata_o); end
        checks++; if (sram_rden_o !== 1'b0 || sram_rdaddr_o !== 12'h007) begin errors++;
            $display("FAIL idle_rdaddr got %0b %h exp 0 007", sram_rden_o, sram_rdaddr_o); end
        cyc();
        #1;
        checks++; if (vld0_o !== 1'b0 || vld1_o !== 1'b0 || rddata_o !== 16'h0000) begin errors++;
            $display("FAIL idle_rddata got vld %0b%0b data %h exp 00 0000", vld0_o, vld1_o, rddata_o); end
    endtask

    task automatic test_contention();
        int n0, n1;
        logic [DW-1:0] exp_d;
        n0 = 0; n1 = 0;
        req0_i = 1'b1; req1_i = 1'b1; addr0_i = 12'h010; addr1_i = 12'h020;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin req0_i = 1'b0; req1_i = 1'b0; end
            #1;
            if (i < 8) begin
                checks++; if (gnt0_o !== (i % 2 == 0) || gnt1_o !== (i % 2 == 1)) begin errors++;
                    $display("FAIL cont_gnt[%0d] got %0b%0b exp %0b%0b", i, gnt0_o, gnt1_o, i % 2 == 0, i % 2 == 1); end
            end
            if (i > 0) begin
                exp_d = ((i - 1) % 2 == 0) ? 16'h1111 : 16'h2222;
                checks++; if (vld0_o !== ((i - 1) % 2 == 0) || vld1_o !== ((i - 1) % 2 == 1) || rddata_o !== exp_d) begin errors++;
                    $display("FAIL cont_ret[%0d] got vld %0b%0b data %h exp data %h", i, vld0_o, vld1_o, rddata_o, exp_d); end
            end
            if (vld0_o === 1'b1) n0++;
            if (vld1_o === 1'b1) n1++;
            cyc();
        end
        checks++; if (n0 != 4 || n1 != 4) begin errors++;
            $display("FAIL cont_count got %0d/%0d exp 4/4", n0, n1); end
    endtask

    task automatic test_bypass();
        // Write to the neighbouring address: no bypass, old data returns.
        req0_i = 1'b1; addr0_i = 12'h3A5;
        wren_i = 1'b1; wraddr_i = 12'h3A6; wrdata_i = 16'hBEEF;
        #1;
        checks++; if (gnt0_o !== 1'b1 || sram_wren_o !== 1'b1) begin errors++;
            $display("FAIL byp_miss_gnt got gnt %0b wren %0b exp 1 1", gnt0_o, sram_wren_o); end
        cyc();
        req0_i = 1'b0; wren_i = 1'b0;
        #1;
        checks++; if (vld0_o !== 1'b1 || rddata_o !== 16'h0001) begin errors++;
            $display("FAIL byp_miss_ret got vld %0b data %h exp 1 0001", vld0_o, rddata_o); end
        // Same-cycle write to the granted address: new data returns.
        req1_i = 1'b1; addr1_i = 12'h3A5;
        wren_i = 1'b1; wraddr_i = 12'h3A5; wrdata_i = 16'hBEEF;
        cyc();
        req1_i = 1'b0; wren_i = 1'b0;
        #1;
        checks++; if (vld1_o !== 1'b1 || rddata_o !== 16'hBEEF) begin errors++;
            $display("FAIL byp_hit_ret got vld %0b data %h exp 1 beef", vld1_o, rddata_o); end
        // Bypass must not linger into the next return.
        req0_i = 1'b1; addr0_i = 12'h010;
        cyc();
        req0_i = 1'b0;
        #1;
        checks++; if (vld0_o !== 1'b1 || rddata_o !== 16'h1111) begin errors++;
            $display("FAIL byp_clear_ret got vld %0b data %h exp 1 1111", vld0_o, rddata_o); end
    endtask

    task automatic test_late_write();
        req0_i = 1'b1; addr0_i = 12'h100;
        cyc();
        req0_i = 1'b0;
        wren_i = 1'b1; wraddr_i = 12'h100; wrdata_i = 16'hCAFE;
        #1;
        checks++; if (vld0_o !== 1'b1 || rddata_o !== 16'h5555) begin errors++;
            $display("FAIL late_wr_ret got vld %0b data %h exp 1 5555", vld0_o, rddata_o); end
        cyc();
        wren_i = 1'b0;
        req0_i = 1'b1; addr0_i = 12'h100;
        cyc();
        req0_i = 1'b0;
        #1;
        checks++; if (vld0_o !== 1'b1 || rddata_o !== 16'hCAFE) begin errors++;
            $display("FAIL late_wr_reread got vld %0b data %h exp 1 cafe", vld0_o, rddata_o); end
    endtask

    task automatic test_midflight_reset();
        req1_i = 1'b1; addr1_i = 12'h020;
        #1;
        checks++; if (gnt1_o !== 1'b1) begin errors++;
            $display("FAIL mid_gnt1 got %0b exp 1", gnt1_o); end
        cyc();
        req1_i = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (vld1_o !== 1'b0 || rddata_o !== 16'h0000) begin errors++;
            $display("FAIL mid_rst_ret got vld1 %0b data %h exp 0 0000", vld1_o, rddata_o); end
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (vld0_o !== 1'b0 || vld1_o !== 1'b0 || rddata_o !== 16'h0000) begin errors++;
            $display("FAIL mid_post_rst got vld %0b%0b data %h exp 00 0000", vld0_o, vld1_o, rddata_o); end
        req0_i = 1'b1; req1_i = 1'b1; addr0_i = 12'h010; addr1_i = 12'h020;
        #1;
        checks++; if (gnt0_o !== 1'b1 || gnt1_o !== 1'b0) begin errors++;
            $display("FAIL mid_tie got %0b%0b exp 10", gnt0_o, gnt1_o); end
        cyc();
        req0_i = 1'b0;
        cyc();
        req1_i = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d;
        bit saw_vld0;
        saw_vld0 = 1'b0;
        req1_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) req1_i = 1'b0;
            else addr1_i = AW'(i);
            #1;
            if (i < 16) begin
                checks++; if (gnt1_o !== 1'b1 || gnt0_o !== 1'b0 || sram_rdaddr_o !== AW'(i)) begin errors++;
                    $display("FAIL stream_gnt[%0d] got %0b%0b %h exp 01 %h", i, gnt0_o, gnt1_o, sram_rdaddr_o, AW'(i)); end
            end
            if (i > 0) begin
                exp_d = 16'hA000 + DW'(i - 1);
                checks++; if (vld1_o !== 1'b1 || rddata_o !== exp_d) begin errors++;
                    $display("FAIL stream_ret[%0d] got vld1 %0b data %h exp 1 %h", i, vld1_o, rddata_o, exp_d); end
            end
            if (vld0_o !== 1'b0) saw_vld0 = 1'b1;
            cyc();
        end
        checks++; if (saw_vld0) begin errors++;
            $display("FAIL stream_vld0 got 1 exp 0"); end
    endtask

    initial begin
        rst = 1'b1; req0_i = 1'b0; req1_i = 1'b0; addr0_i = '0; addr1_i = '0;
        wren_i = 1'b0; wraddr_i = '0; wrdata_i = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_tie_after_reset();
        test_contention();
        test_bypass();
        test_late_write();
        test_midflight_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
